// File: rtl/reg_scoreboard_file.sv
// Decode-stage architectural register file with a per-register pending-write
// scoreboard. Operand reads are combinational with same-cycle writeback
// bypass. Wait flags tell data_distribute which operands it must forward.
// sb_stall holds decode while a destination's pending counter is full.
module reg_scoreboard_file #(
  parameter int PEND_W = 2,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pause,
  input  logic            flush,
  input  logic            dec_valid,
  input  logic [5:0]      dec_r_tag,
  input  logic [14:0]     dec_r_add,
  input  logic            wrd_en1,
  input  logic [6:0]      wrd_add1,
  input  logic [XLEN-1:0] wrd_data1,
  input  logic            wrd_en2,
  input  logic [6:0]      wrd_add2,
  input  logic [XLEN-1:0] wrd_data2,
  output logic [XLEN-1:0] de_rs1,
  output logic [XLEN-1:0] de_rs2,
  output logic [2:0]      de_r_wait,
  output logic [5:0]      de_r_tag,
  output logic [14:0]     de_r_add,
  output logic            sb_stall
);

  // 3 banks (int, fp, aux) x 32 registers, addressed as {tag-1, reg}.
  localparam int NREG = 96;
  localparam logic [PEND_W-1:0] CNT_FULL = '1;

  logic [XLEN-1:0]   regs    [NREG];
  logic [PEND_W-1:0] cnt     [NREG];
  logic [PEND_W-1:0] cnt_nxt [NREG];

  logic [1:0] rs1_tag, rs2_tag, rd_tag;
  logic [6:0] rs1_a, rs2_a, rd_a;
  logic       rd_tracked;
  logic       issue;

  // Unused operands (tag 0) map into bank 0; every consumer gates on the tag,
  // so the index only needs to stay inside the array.
  function automatic logic [6:0] addr_of(input logic [1:0] tag, input logic [4:0] r);
    logic [1:0] bank;
    bank = (tag == 2'd0) ? 2'd0 : tag - 2'd1;
    return {bank, r};
  endfunction

  // Number of writeback ports landing on address a this cycle (0..2).
  function automatic logic [1:0] hit_count(input logic [6:0] a);
    return 2'(wrd_en1 && (wrd_add1 == a)) + 2'(wrd_en2 && (wrd_add2 == a));
  endfunction

  // Port 2 bypass beats port 1 bypass beats the array; x0 and unused read 0.
  function automatic logic [XLEN-1:0] read_opnd(input logic [1:0] tag, input logic [6:0] a);
    if (tag == 2'd0 || a == 7'd0) return '0;
    if (wrd_en2 && wrd_add2 == a) return wrd_data2;
    if (wrd_en1 && wrd_add1 == a) return wrd_data1;
    return regs[a];
  endfunction

  // Waiting means writes are still outstanding after this cycle's writebacks.
  function automatic logic opnd_wait(input logic [1:0] tag, input logic [6:0] a);
    return (tag != 2'd0) && (cnt[a] != '0) && (int'(cnt[a]) != int'(hit_count(a)));
  endfunction

  // Writes to x0 or to the non-existent fourth bank are dropped.
  function automatic logic wr_ok(input logic [6:0] a);
    return (a != 7'd0) && (a[6:5] != 2'b11);
  endfunction

  assign {rd_tag, rs2_tag, rs1_tag} = dec_r_tag;
  assign rs1_a = addr_of(rs1_tag, dec_r_add[4:0]);
  assign rs2_a = addr_of(rs2_tag, dec_r_add[9:5]);
  assign rd_a  = addr_of(rd_tag,  dec_r_add[14:10]);

  assign de_r_tag  = dec_r_tag;
  assign de_r_add  = dec_r_add;
  assign de_rs1    = read_opnd(rs1_tag, rs1_a);
  assign de_rs2    = read_opnd(rs2_tag, rs2_a);
  assign de_r_wait = {opnd_wait(rd_tag, rd_a), opnd_wait(rs2_tag, rs2_a),
                      opnd_wait(rs1_tag, rs1_a)};

  // x0 and unused destinations are never tracked, so they can never stall.
  assign rd_tracked = (rd_tag != 2'd0) && (rd_a != 7'd0);
  assign sb_stall   = dec_valid && rd_tracked && (cnt[rd_a] == CNT_FULL);
  assign issue      = dec_valid && !pause && !sb_stall && !flush;

  // Next pending count per register: +1 on issue, -hits on writeback, floor 0.
  // NOTE: every output of this block is assigned on every path before any
  // conditional, so no latch can be inferred.
  always_comb begin
    int sum;
    for (int i = 0; i < NREG; i++) begin
      sum = int'(cnt[i]) + ((issue && rd_tracked && rd_a == 7'(i)) ? 1 : 0)
            - int'(hit_count(7'(i)));
      cnt_nxt[i] = '0;
      if (!flush && sum > 0) cnt_nxt[i] = PEND_W'(sum);
    end
  end

  // Register array and counter state; port 2 is written last so it wins.
  // NOTE: the register array is reset here because architectural state must
  // read as zero after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      if (wrd_en1 && wr_ok(wrd_add1)) regs[wrd_add1] <= wrd_data1;
      if (wrd_en2 && wr_ok(wrd_add2)) regs[wrd_add2] <= wrd_data2;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard_file.sv
// Self-checking bench for reg_scoreboard_file: a table of directed cycles with
// hand-derived expectations, then randomized traffic checked against a
// register-and-count reference model.
module tb_reg_scoreboard_file;

  localparam int PEND_W = 2;
  localparam int XLEN   = 32;
  localparam int MAXC   = (1 << PEND_W) - 1;

  logic            clk = 1'b0;
  logic            reset, pause, flush, dec_valid;
  logic [5:0]      dec_r_tag;
  logic [14:0]     dec_r_add;
  logic            wrd_en1, wrd_en2;
  logic [6:0]      wrd_add1, wrd_add2;
  logic [XLEN-1:0] wrd_data1, wrd_data2;
  logic [XLEN-1:0] de_rs1, de_rs2;
  logic [2:0]      de_r_wait;
  logic [5:0]      de_r_tag;
  logic [14:0]     de_r_add;
  logic            sb_stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register values and outstanding-write counts.
  logic [XLEN-1:0] mreg [96];
  int              mcnt [96];

  reg_scoreboard_file #(.PEND_W(PEND_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .pause(pause), .flush(flush),
    .dec_valid(dec_valid), .dec_r_tag(dec_r_tag), .dec_r_add(dec_r_add),
    .wrd_en1(wrd_en1), .wrd_add1(wrd_add1), .wrd_data1(wrd_data1),
    .wrd_en2(wrd_en2), .wrd_add2(wrd_add2), .wrd_data2(wrd_data2),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_r_wait(de_r_wait),
    .de_r_tag(de_r_tag), .de_r_add(de_r_add), .sb_stall(sb_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [3:0]  ctl;      // {reset, pause, flush, dec_valid}
    logic [5:0]  tg;
    logic [14:0] ad;
    logic [39:0] w1;       // {en, add[6:0], data[31:0]}
    logic [39:0] w2;
    logic [31:0] e_rs1, e_rs2;
    logic [2:0]  e_wait;
    bit          e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input string n, input logic [3:0] ctl, input logic [5:0] tg,
                   input logic [14:0] ad, input logic [39:0] w1, input logic [39:0] w2,
                   input logic [31:0] r1, input logic [31:0] r2, input logic [2:0] w,
                   input bit s);
    vec_t x;
    x.name = n; x.ctl = ctl; x.tg = tg; x.ad = ad; x.w1 = w1; x.w2 = w2;
    x.e_rs1 = r1; x.e_rs2 = r2; x.e_wait = w; x.e_stall = s;
    vecs.push_back(x);
  endtask

  // ---- model, written from the architectural rules ----
  function automatic int addr(input int tag, input int r);
    return (tag - 1) * 32 + r;
  endfunction

  function automatic int hits(input int a);
    int h = 0;
    if (wrd_en1 && int'(wrd_add1) == a) h++;
    if (wrd_en2 && int'(wrd_add2) == a) h++;
    return h;
  endfunction

  function automatic logic [31:0] m_read(input int tag, input int r);
    int a;
    if (tag == 0) return 32'h0;
    a = addr(tag, r);
    if (a == 0) return 32'h0;
    if (wrd_en2 && int'(wrd_add2) == a) return wrd_data2;
    if (wrd_en1 && int'(wrd_add1) == a) return wrd_data1;
    return mreg[a];
  endfunction

  function automatic logic m_wait(input int tag, input int r);
    int a;
    if (tag == 0) return 1'b0;
    a = addr(tag, r);
    return (mcnt[a] != 0) && (mcnt[a] != hits(a));
  endfunction

  function automatic logic m_stall();
    int t = int'(dec_r_tag[5:4]);
    int a;
    if (!dec_valid || t == 0) return 1'b0;
    a = addr(t, int'(dec_r_add[14:10]));
    return (a != 0) && (mcnt[a] == MAXC);
  endfunction

  task automatic model_update();
    bit iss;
    int rda, n, t;
    if (reset) begin
      for (int a = 0; a < 96; a++) begin mreg[a] = '0; mcnt[a] = 0; end
      return;
    end
    iss = dec_valid && !pause && !m_stall() && !flush;
    t   = int'(dec_r_tag[5:4]);
    rda = (t == 0) ? -1 : addr(t, int'(dec_r_add[14:10]));
    if (rda == 0) rda = -1;
    for (int a = 0; a < 96; a++) begin
      n = mcnt[a] + ((iss && a == rda) ? 1 : 0) - hits(a);
      mcnt[a] = flush ? 0 : ((n < 0) ? 0 : n);
    end
    if (wrd_en1 && wrd_add1 != 7'd0) mreg[wrd_add1] = wrd_data1;
    if (wrd_en2 && wrd_add2 != 7'd0) mreg[wrd_add2] = wrd_data2;
  endtask

  // Inputs are already applied; sample at negedge, then advance one edge.
  task automatic run_cycle(input bit use_tbl, input vec_t x);
    @(negedge clk);
    if (use_tbl) begin
      check({x.name, ".rs1"},   de_rs1, x.e_rs1);
      check({x.name, ".rs2"},   de_rs2, x.e_rs2);
      check({x.name, ".wait"},  32'(de_r_wait), 32'(x.e_wait));
      check({x.name, ".stall"}, 32'(sb_stall), 32'(x.e_stall));
      check({x.name, ".pass"},  32'({de_r_tag, de_r_add}), 32'({dec_r_tag, dec_r_add}));
    end else begin
      check("rnd.rs1", de_rs1, m_read(int'(dec_r_tag[1:0]), int'(dec_r_add[4:0])));
      check("rnd.rs2", de_rs2, m_read(int'(dec_r_tag[3:2]), int'(dec_r_add[9:5])));
      check("rnd.wait", 32'(de_r_wait),
            32'({m_wait(int'(dec_r_tag[5:4]), int'(dec_r_add[14:10])),
                 m_wait(int'(dec_r_tag[3:2]), int'(dec_r_add[9:5])),
                 m_wait(int'(dec_r_tag[1:0]), int'(dec_r_add[4:0]))}));
      check("rnd.stall", 32'(sb_stall), 32'(m_stall()));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  localparam logic [39:0] NO = 40'h0;

  initial begin
    vec_t dummy;
    for (int a = 0; a < 96; a++) begin mreg[a] = '0; mcnt[a] = 0; end
    reset = 1'b1; pause = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    dec_r_tag = '0; dec_r_add = '0;
    wrd_en1 = 1'b0; wrd_add1 = '0; wrd_data1 = '0;
    wrd_en2 = 1'b0; wrd_add2 = '0; wrd_data2 = '0;

    // ctl = {reset, pause, flush, dec_valid}; tg = {rd, rs2, rs1}; ad likewise.
    v("rst_read_x5",   4'b0001, {2'd0,2'd0,2'd1}, {5'd0,5'd0,5'd5},  NO, NO, 0, 0, 3'b000, 0);
    v("issue_x3",      4'b0001, {2'd1,2'd0,2'd0}, {5'd3,5'd0,5'd0},  NO, NO, 0, 0, 3'b000, 0);
    v("x3_wait",       4'b0000, {2'd0,2'd0,2'd1}, {5'd0,5'd0,5'd3},  NO, NO, 0, 0, 3'b001, 0);
    v("x3_bypass",     4'b0000, {2'd0,2'd0,2'd1}, {5'd0,5'd0,5'd3},
      {1'b1,7'h03,32'hDEAD_BEEF}, NO, 32'hDEAD_BEEF, 0, 3'b000, 0);
    v("x3_clear",      4'b0000, {2'd0,2'd0,2'd1}, {5'd0,5'd0,5'd3},  NO, NO, 32'hDEAD_BEEF, 0, 3'b000, 0);
    v("f7_issue1",     4'b0001, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},  NO, NO, 0, 0, 3'b000, 0);
    v("f7_issue2",     4'b0001, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},  NO, NO, 0, 0, 3'b101, 0);
    v("f7_issue3",     4'b0001, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},  NO, NO, 0, 0, 3'b101, 0);
    v("f7_saturate",   4'b0001, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},  NO, NO, 0, 0, 3'b101, 1);
    v("f7_hold",       4'b0001, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},  NO, NO, 0, 0, 3'b101, 1);
    v("f7_wb_stalled", 4'b0001, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},
      {1'b1,7'h27,32'h77}, NO, 32'h77, 0, 3'b101, 1);
    v("f7_unstall",    4'b0000, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},  NO, NO, 32'h77, 0, 3'b101, 0);
    v("f7_dual_wb",    4'b0000, {2'd2,2'd0,2'd2}, {5'd7,5'd0,5'd7},
      {1'b1,7'h27,32'h1}, {1'b1,7'h27,32'h2}, 32'h2, 0, 3'b000, 0);
    v("a5_issue1",     4'b0001, {2'd3,2'd0,2'd3}, {5'd5,5'd0,5'd5},  NO, NO, 0, 0, 3'b000, 0);
    v("a5_issue2",     4'b0001, {2'd3,2'd0,2'd3}, {5'd5,5'd0,5'd5},  NO, NO, 0, 0, 3'b101, 0);
    v("a5_dual_wb",    4'b0000, {2'd3,2'd0,2'd3}, {5'd5,5'd0,5'd5},
      {1'b1,7'h45,32'h1}, {1'b1,7'h45,32'h2}, 32'h2, 0, 3'b000, 0);
    v("a5_after",      4'b0000, {2'd3,2'd0,2'd3}, {5'd5,5'd0,5'd5},  NO, NO, 32'h2, 0, 3'b000, 0);
    v("x0_write",      4'b0001, {2'd1,2'd1,2'd1}, {5'd0,5'd0,5'd0},
      {1'b1,7'h00,32'hFFFF}, NO, 0, 0, 3'b000, 0);
    v("x0_reissue",    4'b0001, {2'd1,2'd1,2'd1}, {5'd0,5'd0,5'd0},  NO, NO, 0, 0, 3'b000, 0);
    v("pause_issue",   4'b0101, {2'd1,2'd0,2'd1}, {5'd9,5'd0,5'd9},  NO, NO, 0, 0, 3'b000, 0);
    v("pause_no_cnt",  4'b0000, {2'd1,2'd0,2'd1}, {5'd9,5'd0,5'd9},  NO, NO, 0, 0, 3'b000, 0);
    v("issue_x10",     4'b0001, {2'd1,2'd0,2'd0}, {5'd10,5'd0,5'd0}, NO, NO, 0, 0, 3'b000, 0);
    v("issue_x11",     4'b0001, {2'd1,2'd0,2'd0}, {5'd11,5'd0,5'd0}, NO, NO, 0, 0, 3'b000, 0);
    v("issue_x12",     4'b0001, {2'd1,2'd0,2'd0}, {5'd12,5'd0,5'd0}, NO, NO, 0, 0, 3'b000, 0);
    v("three_pending", 4'b0000, {2'd1,2'd1,2'd1}, {5'd12,5'd11,5'd10}, NO, NO, 0, 0, 3'b111, 0);
    v("flush_cycle",   4'b0011, {2'd1,2'd1,2'd1}, {5'd12,5'd11,5'd10}, NO, NO, 0, 0, 3'b111, 0);
    v("after_flush",   4'b0000, {2'd1,2'd1,2'd1}, {5'd12,5'd11,5'd10}, NO, NO, 0, 0, 3'b000, 0);
    v("wb_after_flush",4'b0000, {2'd1,2'd1,2'd1}, {5'd12,5'd11,5'd10},
      {1'b1,7'h0A,32'hABCD}, NO, 32'hABCD, 0, 3'b000, 0);
    v("after_wb",      4'b0000, {2'd1,2'd1,2'd1}, {5'd12,5'd11,5'd10}, NO, NO, 32'hABCD, 0, 3'b000, 0);
    v("reset_mid",     4'b1001, {2'd1,2'd0,2'd0}, {5'd10,5'd0,5'd0},
      {1'b1,7'h0A,32'h1234}, NO, 0, 0, 3'b000, 0);
    v("post_reset",    4'b0000, {2'd1,2'd0,2'd1}, {5'd10,5'd0,5'd10}, NO, NO, 0, 0, 3'b000, 0);

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      {reset, pause, flush, dec_valid} = vecs[i].ctl;
      dec_r_tag = vecs[i].tg;
      dec_r_add = vecs[i].ad;
      {wrd_en1, wrd_add1, wrd_data1} = vecs[i].w1;
      {wrd_en2, wrd_add2, wrd_data2} = vecs[i].w2;
      run_cycle(1'b1, vecs[i]);
    end

    // Randomized traffic on a small register set to force collisions.
    dummy = vecs[0];
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 99) < 3);
      pause     = ($urandom_range(0, 99) < 20);
      dec_valid = ($urandom_range(0, 99) < 70);
      dec_r_tag = 6'($urandom_range(0, 63));
      dec_r_add = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      wrd_en1   = ($urandom_range(0, 99) < 40);
      wrd_add1  = {2'($urandom_range(0, 2)), 5'($urandom_range(0, 3))};
      wrd_data1 = $urandom;
      wrd_en2   = ($urandom_range(0, 99) < 40);
      wrd_add2  = {2'($urandom_range(0, 2)), 5'($urandom_range(0, 3))};
      wrd_data2 = $urandom;
      run_cycle(1'b0, dummy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
